ball_balancer_pid_sched: RTL
============================

# ball_balancer_pid_sched

Time-multiplexes one shared PID datapath between the X and Y tilt axes of the ball balancer. Captures per-axis tilt/setpoint samples on their valid strobes and arbitrates round-robin between pending axes. Issues one PID evaluation at a time, waits the datapath's fixed latency, and maps the result to a clamped servo duty per axis. It sits between the angle-measurement front end and the servo PWM generators, replacing the per-axis PID instances.

## Interface
- PID_LAT, 2, enabled cycles from `pid_en` to a valid `pid_out`; legal range 1..15.
- KP_X / KI_X / KD_X, 900 / 0 / 64, X-axis gains (16-bit).
- KP_Y / KI_Y / KD_Y, 900 / 0 / 64, Y-axis gains (16-bit).
- DUTY_NEUTRAL / DUTY_MIN / DUTY_MAX, 150 / 100 / 200, duty mapping constants.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  all state advances and all inputs are sampled only when high.
- x_valid, y_valid  in  1  one-enabled-cycle sample strobes.
- x_tilt, x_setpoint, y_tilt, y_setpoint  in  16  signed angle samples.
- pid_en  out  1  one-enabled-cycle start strobe to the shared PID.
- pid_axis  out  1  0 = X, 1 = Y; selects gains and per-axis PID state.
- pid_error  out  16  signed error for the current evaluation.
- pid_kp, pid_ki, pid_kd  out  16  gains for `pid_axis`.
- pid_out  in  16  signed PID result.
- duty_x, duty_y  out  8  servo duty.
- duty_valid  out  2  bit 0 = X, bit 1 = Y; update strobe.
- overrun  out  2  sticky per-axis flag: a sample was overwritten before it was issued.

## Operation
- Per-axis capture register and pending flag.
  - A valid strobe loads tilt and setpoint into the capture register and sets pending.
  - A valid strobe while pending is already set overwrites the sample and sets the overrun bit.
  - Capture registers are separate from the in-flight operands, so a strobe for the axis currently in flight simply creates a new pending sample.
- FSM states IDLE, ISSUE, WAIT, UPDATE.
  - IDLE: if any axis is pending, grant one axis and go to ISSUE.
    - If only one axis is pending, grant it.
    - If both are pending, grant the axis not served last. After reset, X has priority.
    - On grant, clear that axis's pending flag, then compute `pid_error` = sat16(setpoint − tilt) using a 17-bit signed difference saturated to ±32767/−32768.
    - Latch `pid_axis`, `pid_error` and the gains.
  - ISSUE: `pid_en` = 1 for this enabled cycle; load the wait counter with PID_LAT; go to WAIT.
  - WAIT: decrement the counter each enabled cycle; at 0 go to UPDATE. `pid_axis`, `pid_error` and the gains hold stable.
  - UPDATE: sample `pid_out` and compute d = DUTY_NEUTRAL − pid_out as a 17-bit signed value.
    - The duty is clamped to [DUTY_MIN, DUTY_MAX] and registered into the granted axis's duty output.
    - The granted axis's bit of `duty_valid` pulses.
    - Record the last-served axis and return to IDLE.
- A valid strobe and a grant for the same axis in the same cycle: the grant takes the old sample, and the new sample stays pending (no overrun).
- `overrun` is cleared only by reset.

## Timing
- Reset values:
  - duty_x = duty_y = DUTY_NEUTRAL.
  - duty_valid = 0, pid_en = 0, pid_axis = 0, pid_error = 0, gains = X gains, overrun = 0.
  - FSM = IDLE, pending = 0.
- Reset asserted mid-operation aborts the evaluation; no duty update occurs.
- Latency, in enabled cycles, with the FSM idle:
  - valid at enabled cycle t → pending at t+1 → grant at t+1 → `pid_en` at t+2 → `pid_out` sampled at t+2+PID_LAT → duty and `duty_valid` at t+3+PID_LAT.
- Throughput: one evaluation per PID_LAT+3 enabled cycles.
- While `clk_en` is low, all registered outputs hold, including `pid_en` and `duty_valid`. Consumers qualify both with `clk_en`.

## Structure
- Shared package `ball_balancer_pkg` holds:
  - the `axis_e` enum (AXIS_X, AXIS_Y);
  - the `sched_state_e` enum;
  - the default duty constants (150/100/200);
  - the 16-bit signed angle typedef.
- One sub-module, `pid_duty_map`: combinational 17-bit neutral-minus-output with clamp, parameterised by the three duty constants.

## Test plan
- Reset, then a single x_valid with tilt = 0, setpoint = 100 → pid_error = 100, pid_axis = 0, pid_en pulse at t+2. With pid_out = 30, duty_x = 120 and duty_valid = 01 at t+5 (PID_LAT = 2); duty_y stays 150.
- x_valid and y_valid in the same cycle → X is issued first, Y second. A second simultaneous pair → X first again, because round-robin gives priority to the axis not served last.
- Clamp check:
  - pid_out = −200 → duty 200.
  - pid_out = +500 → duty 100.
  - pid_out = −32768 → duty 200.
- Saturation check: setpoint = 32767, tilt = −32768 → pid_error = 32767. Reversed operands → pid_error = −32768.
- Overrun check: two y_valid strobes while an X evaluation is in flight → overrun = 10, and only the second Y sample is issued.
- clk_en toggling 1-of-3, and reset_n asserted during WAIT:
  - the FSM and duty_valid advance only on enabled cycles;
  - reset returns every output to its reset value with no duty update.

Source files
------------

// File: rtl/ball_balancer_pkg.sv
// Shared types and constants for the ball balancer PID scheduler.
// Axis/state enums, default duty mapping and the saturating error helper.
package ball_balancer_pkg;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_UPDATE = 2'd3
  } sched_state_e;

  localparam int DUTY_NEUTRAL_DEF = 150;
  localparam int DUTY_MIN_DEF     = 100;
  localparam int DUTY_MAX_DEF     = 200;

  typedef logic signed [15:0] angle_t;

  function automatic angle_t sat_sub(angle_t sp, angle_t tl);
    logic signed [16:0] d;
    d = $signed({sp[15], sp}) - $signed({tl[15], tl});
    if (d > 17'sd32767)
      return 16'sh7fff;
    else if (d < -17'sd32768)
      return 16'sh8000;
    else
      return d[15:0];
  endfunction

endpackage

// File: rtl/ball_balancer_pid_sched_duty_map.sv
// Maps a signed PID result onto a clamped servo duty.
// duty = clamp(NEUTRAL - pid_out, MIN, MAX), computed in 17 bits.
module pid_duty_map #(
  parameter int NEUTRAL = 150,
  parameter int MIN     = 100,
  parameter int MAX     = 200
) (
  input  logic [15:0] pid_out,
  output logic [7:0]  duty
);

  logic signed [16:0] po;
  logic signed [16:0] d;
  logic signed [16:0] lo;
  logic signed [16:0] hi;

  always_comb begin
    po = $signed({pid_out[15], pid_out});
    lo = 17'(MIN);
    hi = 17'(MAX);
    d  = 17'(NEUTRAL) - po;
    if (d < lo)
      duty = 8'(MIN);
    else if (d > hi)
      duty = 8'(MAX);
    else
      duty = d[7:0];
  end

endmodule

// File: rtl/ball_balancer_pid_sched.sv
// Round-robin scheduler sharing one PID datapath between X and Y tilt axes.
// Captures samples, issues one evaluation at a time, maps results to duty.
module ball_balancer_pid_sched
  import ball_balancer_pkg::*;
#(
  parameter int          PID_LAT      = 2,
  parameter logic [15:0] KP_X         = 16'd900,
  parameter logic [15:0] KI_X         = 16'd0,
  parameter logic [15:0] KD_X         = 16'd64,
  parameter logic [15:0] KP_Y         = 16'd900,
  parameter logic [15:0] KI_Y         = 16'd0,
  parameter logic [15:0] KD_Y         = 16'd64,
  parameter int          DUTY_NEUTRAL = DUTY_NEUTRAL_DEF,
  parameter int          DUTY_MIN     = DUTY_MIN_DEF,
  parameter int          DUTY_MAX     = DUTY_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        x_valid,
  input  logic        y_valid,
  input  logic [15:0] x_tilt,
  input  logic [15:0] x_setpoint,
  input  logic [15:0] y_tilt,
  input  logic [15:0] y_setpoint,
  output logic        pid_en,
  output logic        pid_axis,
  output logic [15:0] pid_error,
  output logic [15:0] pid_kp,
  output logic [15:0] pid_ki,
  output logic [15:0] pid_kd,
  input  logic [15:0] pid_out,
  output logic [7:0]  duty_x,
  output logic [7:0]  duty_y,
  output logic [1:0]  duty_valid,
  output logic [1:0]  overrun
);

  sched_state_e state;
  logic [3:0]   cnt;
  logic [1:0]   pend;
  logic [1:0]   pend_nxt;
  logic [1:0]   ovr_set;
  logic         last;
  angle_t       x_tl, x_sp, y_tl, y_sp;

  logic         gnt_any;
  logic         gnt_axis;
  logic         gnt_x;
  logic         gnt_y;
  angle_t       gnt_err;
  logic [7:0]   duty_n;

  always_comb begin
    gnt_any  = (state == S_IDLE) && (pend != 2'b00);
    gnt_axis = (pend == 2'b11) ? ~last : pend[1];
    gnt_x    = gnt_any && !gnt_axis;
    gnt_y    = gnt_any && gnt_axis;
    gnt_err  = gnt_axis ? sat_sub(y_sp, y_tl)
                        : sat_sub(x_sp, x_tl);
    // A strobe coinciding with its own grant re-arms pending cleanly
    pend_nxt[0] = x_valid | (pend[0] & ~gnt_x);
    pend_nxt[1] = y_valid | (pend[1] & ~gnt_y);
    ovr_set[0]  = x_valid & pend[0] & ~gnt_x;
    ovr_set[1]  = y_valid & pend[1] & ~gnt_y;
  end

  pid_duty_map #(
    .NEUTRAL (DUTY_NEUTRAL),
    .MIN     (DUTY_MIN),
    .MAX     (DUTY_MAX)
  ) u_map (
    .pid_out (pid_out),
    .duty    (duty_n)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_tl    <= '0;
      x_sp    <= '0;
      y_tl    <= '0;
      y_sp    <= '0;
      pend    <= 2'b00;
      overrun <= 2'b00;
    end else if (clk_en) begin
      if (x_valid) begin
        x_tl <= x_tilt;
        x_sp <= x_setpoint;
      end
      if (y_valid) begin
        y_tl <= y_tilt;
        y_sp <= y_setpoint;
      end
      pend    <= pend_nxt;
      overrun <= overrun | ovr_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last       <= AXIS_Y;
      pid_en     <= 1'b0;
      pid_axis   <= AXIS_X;
      pid_error  <= '0;
      pid_kp     <= KP_X;
      pid_ki     <= KI_X;
      pid_kd     <= KD_X;
      duty_x     <= 8'(DUTY_NEUTRAL);
      duty_y     <= 8'(DUTY_NEUTRAL);
      duty_valid <= 2'b00;
    end else if (clk_en) begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (gnt_any) begin
            pid_axis  <= gnt_axis;
            pid_error <= gnt_err;
            pid_kp    <= gnt_axis ? KP_Y : KP_X;
            pid_ki    <= gnt_axis ? KI_Y : KI_X;
            pid_kd    <= gnt_axis ? KD_Y : KD_X;
            pid_en    <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        (state == S_ISSUE): begin
          pid_en <= 1'b0;
          cnt    <= 4'(PID_LAT);
          state  <= S_WAIT;
        end
        (state == S_WAIT): begin
          cnt <= cnt - 4'd1;
          // Last wait cycle is where pid_out becomes valid
          if (cnt == 4'd1) begin
            if (pid_axis) begin
              duty_y     <= duty_n;
              duty_valid <= 2'b10;
            end else begin
              duty_x     <= duty_n;
              duty_valid <= 2'b01;
            end
            state <= S_UPDATE;
          end
        end
        (state == S_UPDATE): begin
          duty_valid <= 2'b00;
          last       <= pid_axis;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
